// File: rtl/bs_router_pkg.sv
// Shared types and helpers for the round-robin bus router.
package bs_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        DLVR = 2'd2
    } state_e;

    localparam int              ID_W     = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

    // Widest packet the header extractor can handle.
    localparam int MAX_PKT = 256;

    // Destination ID sits in the top w bits of an sz-bit packet.
    function automatic logic [MAX_PKT-1:0] get_dst(input logic [MAX_PKT-1:0] pkt,
                                                   input int                 sz,
                                                   input int                 w);
        logic [MAX_PKT-1:0] mask;
        mask = {MAX_PKT{1'b1}} >> (MAX_PKT - w);
        return (pkt >> (sz - w)) & mask;
    endfunction

endpackage

// File: rtl/bs_rr_pick.sv
// Combinational rotate-priority picker: first requester at or after ptr,
// wrapping from n-1 back to 0.
module bs_rr_pick #(
    parameter int n  = 8,
    parameter int PW = (n > 1) ? $clog2(n) : 1
) (
    input  logic [n-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    // Scan from the farthest slot back toward ptr so the nearest requester wins.
    always_comb begin
        int j;
        j       = 0;
        gnt_idx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (req[PW'(j)]) gnt_idx = PW'(j);
        end
        any = |req;
    end

endmodule

// File: rtl/bs_rr_router_n.sv
// N-driver shared-bus router: round-robin pick of a source FIFO, one packet
// in flight, address-based delivery with per-destination back-pressure.
// Optional macro BS_BCAST_EN: destination ID bcast fans out to every
// driver except the sender; without it bcast is just a bad ID and dropped.
//
// Strobe semantics: pop[d] is a one-cycle strobe; the source FIFO presents
// its head word on D_pop (fall-through) and advances on the edge where
// pop[d] is high. push[d] is likewise a one-cycle strobe, only ever raised
// while full[d] is low; the word on D_push is taken at that edge.
module bs_rr_router_n
    import bs_router_pkg::*;
#(
    parameter int              pckg_sz = 16,
    parameter int              drvrs   = 8,
    parameter int              id_w    = ID_W,
    parameter logic [id_w-1:0] bcast   = BCAST_ID
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    output logic [drvrs-1:0]           pop,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    input  logic [drvrs-1:0]           full,
    output logic [drvrs-1:0]           push,
    output logic [drvrs*pckg_sz-1:0]   D_push,
    output logic                       busy,
    output logic                       drop
);

    localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

    state_e               state_q, state_d;
    logic [PW-1:0]        gnt_q, rr_ptr_q, pick_idx;
    logic                 pick_any;
    logic [pckg_sz-1:0]   data_q, pop_data;
    logic [id_w-1:0]      dst;
    logic [drvrs-1:0]     dst_oh, bc_mask;
    logic                 is_bcast, in_range;

    bs_rr_pick #(.n(drvrs), .PW(PW)) u_pick (
        .req     (pndng),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Select the head word of the granted source FIFO.
    always_comb begin
        pop_data = '0;
        for (int d = 0; d < drvrs; d++) begin
            if (PW'(d) == gnt_q) pop_data = D_pop[d*pckg_sz +: pckg_sz];
        end
    end

    // Decode the captured packet's destination.
    always_comb begin
        dst      = id_w'(get_dst(MAX_PKT'(data_q), pckg_sz, id_w));
        dst_oh   = drvrs'(1) << dst;
        bc_mask  = ~(drvrs'(1) << gnt_q);
        is_bcast = (dst == bcast);
        in_range = (int'(dst) < drvrs) && !is_bcast;
    end

    // State, grant, round-robin pointer and packet register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_any) gnt_q <= pick_idx;
            if (state_q == POP) begin
                data_q   <= pop_data;
                rr_ptr_q <= (int'(gnt_q) == drvrs - 1) ? '0 : gnt_q + PW'(1);
            end
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d = state_q;
        pop     = '0;
        push    = '0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) state_d = POP;
            end
            POP: begin
                pop[gnt_q] = 1'b1;
                state_d    = DLVR;
            end
            DLVR: begin
`ifdef BS_BCAST_EN
                if (is_bcast) begin
                    // All receivers must be ready together; one shared push.
                    if ((full & bc_mask) == '0) begin
                        push    = bc_mask;
                        state_d = IDLE;
                    end
                end else
`endif
                if (in_range) begin
                    // Stall with no timeout until the destination has room.
                    if ((full & dst_oh) == '0) begin
                        push    = dst_oh;
                        state_d = IDLE;
                    end
                end else begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign D_push = {drvrs{data_q}};

endmodule

// File: tb/tb_bs_rr_router_n.sv
// Self-checking bench for bs_rr_router_n (drvrs=8, pckg_sz=16).
module tb_bs_rr_router_n;

  localparam int N = 8;
  localparam int W = 16;
  localparam int RW = N + 1 + W;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   pndng, pop, full, push;
  logic [N*W-1:0] d_pop, d_push;
  logic           busy, drop;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Expected deliveries: {push mask, drop, data}
  logic [RW-1:0]  exp_q[$];
  logic [W-1:0]   src_q[N][$];

  typedef struct {
    int           src;
    logic [W-1:0] pkt;
    logic [N-1:0] exp_push;
    logic         exp_drop;
  } vec_t;

  vec_t vecs[6];

  bs_rr_router_n #(.pckg_sz(W), .drvrs(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .pop    (pop),
    .D_pop  (d_pop),
    .full   (full),
    .push   (push),
    .D_push (d_push),
    .busy   (busy),
    .drop   (drop)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pndng = '0;
    full  = '0;
    d_pop = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pop", pop, 0);
    chk("reset_push", push, 0);
    chk("reset_busy", busy, 0);
    chk("reset_drop", drop, 0);
    chk("reset_dpush", d_push[W-1:0], 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a pop strobe at a negedge; returns whether it came.
  task automatic wait_pop(input string name, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (pop != 0) seen = 1'b1;
    end
    chk({name, "_pop_seen"}, seen, 1);
  endtask

  // driver task: one packet from a single source, checked end to end
  task automatic run_single(input vec_t v);
    bit seen;
    pndng = N'(1) << v.src;
    d_pop = '0;
    d_pop[v.src*W +: W] = v.pkt;
    wait_pop("single", seen);
    chk("single_pop", pop, N'(1) << v.src);
    chk("single_push_during_pop", push, 0);
    @(posedge clk);
    #1;
    pndng = '0;
    d_pop = '0;
    @(negedge clk);
    chk("single_push", push, v.exp_push);
    chk("single_drop", drop, v.exp_drop);
    chk("single_data", d_push, {N{v.pkt}});
    chk("single_no_pop", pop, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single_idle_busy", busy, 0);
    chk("single_drop_one_cycle", drop, 0);
    chk("single_push_one_cycle", push, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic fairness();
    bit seen;
    int last_cyc;
    pndng = '1;
    full  = '0;
    for (int d = 0; d < N; d++) d_pop[d*W +: W] = {8'h00, 8'(d)};
    last_cyc = 0;
    for (int k = 0; k <= N; k++) begin
      wait_pop("fair", seen);
      chk("fair_grant", pop, N'(1) << (k % N));
      if (k > 0) chk("fair_period", cyc - last_cyc, 3);
      last_cyc = cyc;
      if (k == N) begin
        @(posedge clk);
        #1;
        pndng = '0;
      end
      @(negedge clk);
      chk("fair_push", push, 1);
    end
    @(posedge clk);
    #1;
    d_pop = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic back_pressure();
    bit seen;
    full  = 8'h04;
    pndng = N'(1) << 5;
    d_pop = '0;
    d_pop[5*W +: W] = 16'h0255;
    wait_pop("bp", seen);
    chk("bp_pop", pop, 8'h20);
    @(posedge clk);
    #1;
    pndng = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_busy", busy, 1);
      chk("bp_push_low", push, 0);
      if (i < 4) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    full = '0;
    @(negedge clk);
    chk("bp_push", push, 8'h04);
    chk("bp_data", d_push[W-1:0], 16'h0255);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_dlvr();
    bit seen;
    full  = 8'h08;
    pndng = N'(1) << 5;
    d_pop = '0;
    d_pop[5*W +: W] = 16'h0377;
    wait_pop("rst", seen);
    @(posedge clk);
    #1;
    pndng = '0;
    @(negedge clk);
    chk("rst_stalled_busy", busy, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_async_pop", pop, 0);
    chk("rst_async_push", push, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_data", d_push[W-1:0], 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    full  = '0;
    d_pop = '0;
    pndng = 8'b0100_0100;
    wait_pop("rst_after", seen);
    chk("rst_first_grant", pop, 8'h04);
    @(posedge clk);
    #1;
    pndng = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_repop_busy", busy, 0);
  endtask

  // Randomised traffic against a transaction-level reference model.
  task automatic random_round(inout int mptr);
    int pend, g, cycles, r, left;
    bit done;
    logic [W-1:0]  pkt;
    logic [7:0]    dst;
    logic [N-1:0]  mask;
    logic          dbit;
    logic [RW-1:0] e;
    for (int d = 0; d < N; d++) begin
      int cnt;
      cnt = $urandom_range(0, 4);
      for (int k = 0; k < cnt; k++) begin
        r = $urandom_range(0, 11);
        if (r < 8)       dst = 8'(r);
        else if (r == 8) dst = 8'h08;
        else if (r == 9) dst = 8'h80;
        else             dst = 8'hFF;
        src_q[d].push_back({dst, 8'($urandom_range(0, 255))});
      end
    end
    pend = -1;
    cycles = 0;
    done = 1'b0;
    while (!done && cycles < 3000) begin
      @(posedge clk);
      #1;
      if (pend >= 0) begin
        void'(src_q[pend].pop_front());
        pend = -1;
      end
      for (int d = 0; d < N; d++) begin
        pndng[d] = (src_q[d].size() > 0);
        d_pop[d*W +: W] = (src_q[d].size() > 0) ? src_q[d][0] : '0;
        full[d] = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      if (push != 0 || drop) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_delivery", {push, drop}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_delivery", {push, drop, d_push[W-1:0]}, e);
          chk("rnd_lanes", d_push, {N{e[W-1:0]}});
        end
        chk("rnd_push_vs_full", push & full, 0);
      end
      if (pop != 0) begin
        g = -1;
        for (int i = 0; i < N && g < 0; i++) begin
          if (src_q[(mptr + i) % N].size() > 0) g = (mptr + i) % N;
        end
        if (g < 0) begin
          chk("rnd_pop_without_request", pop, 0);
        end else begin
          chk("rnd_grant", pop, N'(1) << g);
          pkt  = src_q[g][0];
          pend = g;
          mptr = (g + 1) % N;
          dst  = pkt[W-1 -: 8];
          mask = '0;
          dbit = 1'b0;
`ifdef BS_BCAST_EN
          if (dst == 8'hFF) mask = ~(N'(1) << g);
          else
`endif
          if (int'(dst) < N) mask = N'(1) << dst;
          else dbit = 1'b1;
          exp_q.push_back({mask, dbit, pkt});
        end
      end
      left = 0;
      for (int d = 0; d < N; d++) left += src_q[d].size();
      done = (left == 0) && (exp_q.size() == 0) && (pend < 0) && !busy;
      cycles++;
    end
    if (!done) chk("rnd_timeout_drained", 0, 1);
    pndng = '0;
    full  = '0;
    d_pop = '0;
  endtask

  initial begin
    int mptr;
    vecs[0] = '{src: 3, pkt: 16'h0512, exp_push: 8'h20, exp_drop: 1'b0};
    vecs[1] = '{src: 1, pkt: 16'h0A00, exp_push: 8'h00, exp_drop: 1'b1};
`ifdef BS_BCAST_EN
    vecs[2] = '{src: 4, pkt: 16'hFF33, exp_push: 8'hEF, exp_drop: 1'b0};
`else
    vecs[2] = '{src: 4, pkt: 16'hFF33, exp_push: 8'h00, exp_drop: 1'b1};
`endif
    vecs[3] = '{src: 6, pkt: 16'h0634, exp_push: 8'h40, exp_drop: 1'b0};
    vecs[4] = '{src: 0, pkt: 16'h07A5, exp_push: 8'h80, exp_drop: 1'b0};
    vecs[5] = '{src: 7, pkt: 16'h0811, exp_push: 8'h00, exp_drop: 1'b1};

    do_reset();
    for (int i = 0; i < 6; i++) run_single(vecs[i]);

    do_reset();
    fairness();
    back_pressure();
    reset_mid_dlvr();

    do_reset();
    mptr = 0;
    for (int r = 0; r < 4; r++) random_round(mptr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
